raster_address_gen: RTL

//  Walks a rectangle (x0,y0,w,h) row-major over a SCREEN_W x SCREEN_H framebuffer.

---
 rtl/raster_address_gen_if.sv | 30 +++
 rtl/raster_address_gen.sv | 118 +++++++++++
 2 files changed

// File: rtl/raster_address_gen_if.sv
// Pixel-walk request and output stream bundle for raster_address_gen.
// The master side is the address generator; the slave side is the requester/consumer.
interface raster_address_gen_if #(
  parameter int X_BITS    = 8,
  parameter int Y_BITS    = 7,
  parameter int ADDR_BITS = 15
);
  logic                 start;
  logic [X_BITS-1:0]    x0;
  logic [Y_BITS-1:0]    y0;
  logic [X_BITS-1:0]    w;
  logic [Y_BITS-1:0]    h;
  logic                 out_ready;
  logic                 out_valid;
  logic [X_BITS-1:0]    x;
  logic [Y_BITS-1:0]    y;
  logic [ADDR_BITS-1:0] mem_address;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, x0, y0, w, h, out_ready,
    output out_valid, x, y, mem_address, busy, done
  );

  modport slave (
    output start, x0, y0, w, h, out_ready,
    input  out_valid, x, y, mem_address, busy, done
  );
endinterface

// File: rtl/raster_address_gen.sv
// Row-major rectangle walker over a SCREEN_W x SCREEN_H framebuffer with valid/ready output.
// Optional macro CLIP_EN: off-screen pixels are skipped instead of presented.
module raster_address_gen #(
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120,
  parameter int X_BITS    = 8,
  parameter int Y_BITS    = 7,
  parameter int ADDR_BITS = 15
) (
  input  logic                 clock,
  input  logic                 resetn,
  raster_address_gen_if.master bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [X_BITS:0]      X_ONE    = (X_BITS+1)'(1);
  localparam logic [Y_BITS:0]      Y_ONE    = (Y_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);
  // Row wrap adds SCREEN_W-(w-1); folded as (SCREEN_W+1) - w.
  localparam logic [ADDR_BITS-1:0] ROW_STEP = ADDR_BITS'(SCREEN_W + 1);

  state_t               state, state_nxt;
  logic [X_BITS-1:0]    x0_q, w_q;
  logic [Y_BITS-1:0]    y0_q, h_q;
  logic [X_BITS:0]      x_q, end_x;
  logic [Y_BITS:0]      y_q, end_y;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 row_end, last_px, clipped, advance;

  // Constant multiply by SCREEN_W unrolled into shifted adds of the row index.
  function automatic logic [ADDR_BITS-1:0] row_base(input logic [Y_BITS-1:0] row);
    logic [ADDR_BITS-1:0] acc;
    acc = '0;
    for (int i = 0; i < ADDR_BITS; i++)
      if (SCREEN_W[i]) acc = acc + (ADDR_BITS'(row) << i);
    return acc;
  endfunction

  // One extra bit keeps x0+w-1 / y0+h-1 from aliasing onto a small coordinate.
  assign end_x   = {1'b0, x0_q} + {1'b0, w_q} - X_ONE;
  assign end_y   = {1'b0, y0_q} + {1'b0, h_q} - Y_ONE;
  assign row_end = (x_q == end_x);
  assign last_px = row_end && (y_q == end_y);

`ifdef CLIP_EN
  localparam logic [X_BITS:0] X_LIMIT = (X_BITS+1)'(SCREEN_W);
  localparam logic [Y_BITS:0] Y_LIMIT = (Y_BITS+1)'(SCREEN_H);
  assign clipped = (x_q >= X_LIMIT) || (y_q >= Y_LIMIT);
`else
  assign clipped = 1'b0;
`endif

  // A clipped pixel is consumed without a handshake.
  assign advance = (state == RUN) && (clipped || bus.out_ready);

  assign bus.out_valid   = (state == RUN) && !clipped;
  assign bus.x           = x_q[X_BITS-1:0];
  assign bus.y           = y_q[Y_BITS-1:0];
  assign bus.mem_address = addr_q;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);

  // NOTE: every output of a combinational block gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.start) state_nxt = (bus.w == '0 || bus.h == '0) ? DONE : LOAD;
      LOAD: state_nxt = RUN;
      RUN:  if (advance && last_px) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state  <= IDLE;
      x0_q   <= '0;
      y0_q   <= '0;
      w_q    <= '0;
      h_q    <= '0;
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (bus.start) begin
          x0_q <= bus.x0;
          y0_q <= bus.y0;
          w_q  <= bus.w;
          h_q  <= bus.h;
        end
        LOAD: begin
          x_q    <= {1'b0, x0_q};
          y_q    <= {1'b0, y0_q};
          addr_q <= row_base(y0_q) + ADDR_BITS'(x0_q);
        end
        RUN: if (advance && !last_px) begin
          if (row_end) begin
            x_q    <= {1'b0, x0_q};
            y_q    <= y_q + Y_ONE;
            addr_q <= addr_q + ROW_STEP - ADDR_BITS'(w_q);
          end else begin
            x_q    <= x_q + X_ONE;
            addr_q <= addr_q + ADDR_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
